fifo_uart_tx: RTL and testbench

//  Read-side consumer for the byte FIFO. Pops one byte whenever the FIFO is
//  non-empty and serialises it on a UART 8N1 line: start bit, 8 data bits LSB

---
 rtl/fifo_uart_tx.sv | 129 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO onto a UART 8N1 line, one pop per frame.
// Every output is registered; fifo_empty is sampled only in IDLE and the final STOP cycle.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       frame_cnt
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PEN  = (CLKS_PER_BIT > 1) ? TW'(CLKS_PER_BIT - 2) : '0;
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]        state;
    logic [TW-1:0]     timer;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic              bit_end;

    always_comb begin
        bit_end  = (timer == T_LAST);
        shreg_nx = shreg >> 1;
    end

    // tx/tx_done are registered, so they are set on the edge entering the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            fifo_rd   <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            frame_cnt <= '0;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            fifo_rd <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state   <= POP;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: state <= LOAD;
                LOAD: begin
                    shreg <= fifo_dout;
                    state <= START;
                    tx    <= 1'b0;
                    timer <= '0;
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shreg[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == B_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                            // With one cycle per bit the first STOP cycle is also the last.
                            if (CLKS_PER_BIT == 1) begin
                                tx_done   <= 1'b1;
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg_nx;
                            tx      <= shreg_nx[0];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (!fifo_empty) begin
                            state   <= POP;
                            fifo_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == T_PEN) begin
                            tx_done   <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instances at CLKS_PER_BIT=4 and 1 fed by queue FIFOs,
// checked every cycle against a frame-position model plus literal expectations.
module tb_fifo_uart_tx;
    localparam int CPB0 = 4;
    localparam int CPB1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifo_empty, fifo_rd, tx, busy, tx_done, glitch;
    logic [7:0]  fifo_dout [2];
    logic [15:0] frame_cnt [2];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB0), .DATA_W(8)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
        .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]),
        .frame_cnt(frame_cnt[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
        .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]),
        .frame_cnt(frame_cnt[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    function automatic int cpb(input int k);
        return (k == 0) ? CPB0 : CPB1;
    endfunction

    // One busy period spans POP, LOAD and 10 serial bits.
    function automatic int flen(input int k);
        return 2 + 10 * cpb(k);
    endfunction

    // Model: position within the busy period, byte captured at the end of LOAD.
    bit          m_valid = 1'b0;
    bit          m_busy   [2];
    int          m_p      [2];
    logic [7:0]  m_byte   [2];
    int unsigned m_frames [2];

    function automatic bit exp_tx(input int k);
        int b;
        if (!m_busy[k] || m_p[k] < 2) return 1'b1;
        b = (m_p[k] - 2) / cpb(k);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[k][b-1];
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst === 1'b1) begin
            m_valid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_p[k] = 0;
                m_frames[k] = 0;
            end
        end else if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k]) begin
                    if (fifo_empty[k] == 1'b0) begin
                        m_busy[k] = 1'b1;
                        m_p[k] = 0;
                    end
                end else if (m_p[k] == flen(k) - 1) begin
                    if (fifo_empty[k] == 1'b0) m_p[k] = 0;
                    else m_busy[k] = 1'b0;
                end else begin
                    if (m_p[k] == 1) m_byte[k] = fifo_dout[k];
                    m_p[k]++;
                    if (m_p[k] == flen(k) - 1) m_frames[k] = (m_frames[k] + 1) % 65536;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk("tx", k, 32'(tx[k]), 32'(exp_tx(k)));
                chk("fifo_rd", k, 32'(fifo_rd[k]), 32'(m_busy[k] && m_p[k] == 0));
                chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
                chk("tx_done", k, 32'(tx_done[k]), 32'(m_busy[k] && m_p[k] == flen(k) - 1));
                chk("frame_cnt", k, 32'(frame_cnt[k]), 32'(m_frames[k][15:0]));
            end
        end
    end

    // Bench FIFO, pulse counters and a line decoder, all advanced once per cycle.
    logic [7:0] q    [2][$];
    logic [8:0] rx   [2][$];
    int         gaps [2][$];
    int         rd_cnt [2];
    int         done_cnt [2];
    bit         dec_on [2];
    bit         gap_on [2];
    int         dec_cnt [2];
    int         gap_cnt [2];
    logic [8:0] dec_sh [2];

    task automatic cycle();
        int c;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (fifo_rd[k] === 1'b1) begin
                rd_cnt[k]++;
                if (q[k].size() > 0) fifo_dout[k] = q[k].pop_front();
                else fifo_dout[k] = 8'h00;
            end
            if (tx_done[k] === 1'b1) done_cnt[k]++;
            fifo_empty[k] = (q[k].size() == 0) && !glitch[k];
            if (rst === 1'b1) begin
                dec_on[k] = 1'b0;
                gap_on[k] = 1'b0;
            end else begin
                if (!dec_on[k] && tx[k] === 1'b0) begin
                    dec_on[k] = 1'b1;
                    dec_cnt[k] = 0;
                    if (gap_on[k]) gaps[k].push_back(gap_cnt[k]);
                    gap_on[k] = 1'b0;
                end else if (!dec_on[k] && gap_on[k]) begin
                    gap_cnt[k]++;
                end
                if (dec_on[k]) begin
                    c = dec_cnt[k];
                    if (c % cpb(k) == cpb(k) / 2 && c / cpb(k) >= 1) dec_sh[k][c / cpb(k) - 1] = tx[k];
                    dec_cnt[k]++;
                    if (dec_cnt[k] == 10 * cpb(k)) begin
                        dec_on[k] = 1'b0;
                        rx[k].push_back(dec_sh[k]);
                        gap_on[k] = 1'b1;
                        gap_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        q[k].push_back(b);
        fifo_empty[k] = 1'b0;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            rd_cnt[k] = 0;
            done_cnt[k] = 0;
            rx[k].delete();
            gaps[k].delete();
            gap_on[k] = 1'b0;
        end
    endtask

    task automatic check_rx(input int k, input logic [7:0] e [5], input int n);
        chk("rx_count", k, 32'(rx[k].size()), 32'(n));
        for (int i = 0; i < n && i < rx[k].size(); i++)
            chk("rx_frame", k, 32'(rx[k][i]), 32'({1'b1, e[i]}));
    endtask

    initial begin
        int found;
        int lows;
        int len;
        rst = 1'b1;
        fifo_empty = '1;
        glitch = '0;
        fifo_dout[0] = 8'h00;
        fifo_dout[1] = 8'h00;
        clear_obs();

        // Reset and quiet idle.
        repeat (2) cycle();
        rst = 1'b0;
        repeat (50) cycle();
        for (int k = 0; k < 2; k++) begin
            chk("idle_tx", k, 32'(tx[k]), 32'd1);
            chk("idle_busy", k, 32'(busy[k]), 32'd0);
            chk("idle_frame_cnt", k, 32'(frame_cnt[k]), 32'd0);
            chk("idle_rd_cnt", k, 32'(rd_cnt[k]), 32'd0);
        end

        // Single byte with latency pinned: rd next cycle, start bit two cycles later.
        clear_obs();
        push(0, 8'hA1);
        cycle();
        chk("lat_rd", 0, 32'(fifo_rd[0]), 32'd1);
        cycle();
        chk("lat_load_rd", 0, 32'(fifo_rd[0]), 32'd0);
        chk("lat_load_tx", 0, 32'(tx[0]), 32'd1);
        cycle();
        chk("lat_start_tx", 0, 32'(tx[0]), 32'd0);
        repeat (60) cycle();
        chk("single_rd_cnt", 0, 32'(rd_cnt[0]), 32'd1);
        chk("single_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
        chk("single_frame_cnt", 0, 32'(frame_cnt[0]), 32'd1);
        check_rx(0, '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // Burst of five queued bytes.
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        clear_obs();
        push(0, 8'hA1); push(0, 8'h1B); push(0, 8'hEE); push(0, 8'h55); push(0, 8'hBF);
        repeat (230) cycle();
        chk("burst_rd_cnt", 0, 32'(rd_cnt[0]), 32'd5);
        chk("burst_done_cnt", 0, 32'(done_cnt[0]), 32'd5);
        chk("burst_frame_cnt", 0, 32'(frame_cnt[0]), 32'd5);
        check_rx(0, '{8'hA1, 8'h1B, 8'hEE, 8'h55, 8'hBF}, 5);
        chk("burst_gap_count", 0, 32'(gaps[0].size()), 32'd4);
        foreach (gaps[0][i]) chk("burst_gap", 0, 32'(gaps[0][i]), 32'd2);

        // Empty rises after POP and glitches low mid-frame: no extra pop.
        clear_obs();
        push(0, 8'h3C);
        repeat (12) cycle();
        glitch[0] = 1'b1;
        repeat (5) cycle();
        glitch[0] = 1'b0;
        repeat (50) cycle();
        chk("empty_rd_cnt", 0, 32'(rd_cnt[0]), 32'd1);
        chk("empty_busy", 0, 32'(busy[0]), 32'd0);
        chk("empty_frame_cnt", 0, 32'(frame_cnt[0]), 32'd6);
        check_rx(0, '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // Reset in the third data bit of 0x55; 0xC3 follows cleanly.
        clear_obs();
        push(0, 8'h55);
        push(0, 8'hC3);
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            cycle();
            if (tx[0] === 1'b0) found = 1;
        end
        chk("rst_start_seen", 0, 32'(found), 32'd1);
        repeat (12) cycle();
        chk("rst_mid_bit2", 0, 32'(tx[0]), 32'd1);
        rst = 1'b1;
        cycle();
        chk("rst_tx", 0, 32'(tx[0]), 32'd1);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_frame_cnt", 0, 32'(frame_cnt[0]), 32'd0);
        rst = 1'b0;
        repeat (60) cycle();
        chk("rst_rd_cnt", 0, 32'(rd_cnt[0]), 32'd2);
        chk("rst_after_frame_cnt", 0, 32'(frame_cnt[0]), 32'd1);
        check_rx(0, '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // One cycle per bit with 0xFF.
        clear_obs();
        push(1, 8'hFF);
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            cycle();
            if (tx[1] === 1'b0) found = 1;
        end
        chk("cpb1_start_seen", 1, 32'(found), 32'd1);
        lows = 1;
        len = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            len++;
            if (tx[1] === 1'b0) lows++;
            if (tx_done[1] === 1'b1) break;
        end
        chk("cpb1_low_cycles", 1, 32'(lows), 32'd1);
        chk("cpb1_frame_len", 1, 32'(len), 32'd10);
        repeat (5) cycle();
        chk("cpb1_frame_cnt", 1, 32'(frame_cnt[1]), 32'd1);
        check_rx(1, '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
